fetch_unit: RTL and testbench

Instruction-fetch stage directly upstream of the control unit and datapath. Holds the PC, issues a request/acknowledge read to instruction memory, and registers the returned word. Presents the word to decode (opcode bits [31:26] drive the control unit's opcode input) under a valid/ready handshake. When the instruction is consumed, computes the next PC from the control unit's branch/jump outputs and the ALU zero flag.

---
 rtl/mips_pkg.sv | 21 ++
 rtl/next_pc_calc.sv | 33 +++
 rtl/fetch_unit.sv | 122 ++++++++++++
 tb/tb_fetch_unit.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the fetch stage: instruction field geometry,
// fetch FSM state encoding and immediate helpers.
package mips_pkg;

    localparam int INSTR_W = 32;
    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 26;
    localparam int IMM_W   = 16;
    localparam int JADDR_W = 26;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_VALID = 2'd2;
    localparam logic [1:0] S_ERR   = 2'd3;

    // Sign-extended branch offset already scaled to a byte distance.
    function automatic logic [INSTR_W-1:0] sext_imm_x4(input logic [IMM_W-1:0] imm);
        return {{(INSTR_W - IMM_W - 2){imm[IMM_W-1]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: jump target, taken-branch target or
// sequential PC. Jump has priority over branch.
module next_pc_calc
    import mips_pkg::*;
(
    input  logic [INSTR_W-1:0] i_pc_plus4,
    input  logic [JADDR_W-1:0] i_jidx,
    input  logic               i_branch,
    input  logic               i_zero,
    input  logic               i_jump,
    output logic [INSTR_W-1:0] o_next_pc
);

    logic [INSTR_W-1:0] w_branch_tgt;
    logic [INSTR_W-1:0] w_jump_tgt;

    // The branch immediate is the low half of the jump index field.
    assign w_branch_tgt = i_pc_plus4 + sext_imm_x4(i_jidx[IMM_W-1:0]);
    assign w_jump_tgt   = {i_pc_plus4[INSTR_W-1:INSTR_W-4], i_jidx, 2'b00};

    // Priority select of the PC that follows the retiring instruction
    always_comb begin
        o_next_pc = i_pc_plus4;
        if (i_jump) begin
            o_next_pc = w_jump_tgt;
        end else if (i_branch && i_zero) begin
            o_next_pc = w_branch_tgt;
        end else begin
            o_next_pc = i_pc_plus4;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, registered
// instruction handed to decode under valid/ready, next PC chosen on retire.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 16
)(
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_instr,
    output logic        o_instr_valid,
    input  logic        i_instr_ready,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    input  logic        i_branch,
    input  logic        i_zero,
    input  logic        i_jump,
    output logic        o_fetch_err
);

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [INSTR_W-1:0] r_pc;
    logic [INSTR_W-1:0] r_pc_plus4;
    logic [INSTR_W-1:0] r_instr;
    logic [7:0]         r_wait;
    logic               r_req;
    logic               r_valid;
    logic               r_err;
    logic               w_retire;
    logic [INSTR_W-1:0] w_next_pc;

    assign w_retire = (r_state == S_VALID) && i_instr_ready;

    next_pc_calc u_next_pc (
        .i_pc_plus4 (r_pc_plus4),
        .i_jidx     (r_instr[JADDR_W-1:0]),
        .i_branch   (i_branch),
        .i_zero     (i_zero),
        .i_jump     (i_jump),
        .o_next_pc  (w_next_pc)
    );

    // Fetch sequencing; an ack in the final allowed wait cycle still wins
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_REQ;
            end
            S_REQ: begin
                if (i_imem_ack) begin
                    w_state_nxt = S_VALID;
                end else if (r_wait == WAIT_LAST) begin
                    w_state_nxt = S_ERR;
                end else begin
                    w_state_nxt = S_REQ;
                end
            end
            S_VALID: begin
                if (i_instr_ready) begin
                    w_state_nxt = S_REQ;
                end else begin
                    w_state_nxt = S_VALID;
                end
            end
            S_ERR: begin
                w_state_nxt = S_ERR;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, wait counter, captured instruction and PC registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_pc_plus4 <= RESET_PC + 32'd4;
            r_instr    <= 32'd0;
            r_wait     <= 8'd0;
            r_req      <= 1'b0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= (w_state_nxt == S_REQ);
            r_valid <= (w_state_nxt == S_VALID);
            r_err   <= (w_state_nxt == S_ERR);
            if (r_state == S_REQ) begin
                if (i_imem_ack) begin
                    r_instr <= i_imem_rdata;
                    r_wait  <= 8'd0;
                end else begin
                    r_wait  <= r_wait + 8'd1;
                end
            end
            if (w_retire) begin
                r_pc       <= w_next_pc;
                r_pc_plus4 <= w_next_pc + 32'd4;
            end
        end
    end

    assign o_imem_req    = r_req;
    assign o_imem_addr   = r_pc;
    assign o_instr       = r_instr;
    assign o_instr_valid = r_valid;
    assign o_pc          = r_pc;
    assign o_pc_plus4    = r_pc_plus4;
    assign o_fetch_err   = r_err;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: transaction-level reference model,
// per-cycle compare, directed scenarios and a randomized run.
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam int          MW  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ack = 1'b0;
    logic [31:0] i_imem_rdata = 32'd0;
    logic [31:0] o_instr;
    logic        o_instr_valid;
    logic        i_instr_ready = 1'b0;
    logic [31:0] o_pc;
    logic [31:0] o_pc_plus4;
    logic        i_branch = 1'b0;
    logic        i_zero = 1'b0;
    logic        i_jump = 1'b0;
    logic        o_fetch_err;

    fetch_unit #(.RESET_PC(RPC), .MAX_WAIT(MW)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_ack    (i_imem_ack),
        .i_imem_rdata  (i_imem_rdata),
        .o_instr       (o_instr),
        .o_instr_valid (o_instr_valid),
        .i_instr_ready (i_instr_ready),
        .o_pc          (o_pc),
        .o_pc_plus4    (o_pc_plus4),
        .i_branch      (i_branch),
        .i_zero        (i_zero),
        .i_jump        (i_jump),
        .o_fetch_err   (o_fetch_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    // Next PC from the ISA rules, in plain arithmetic
    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] ins,
                                               input logic br, input logic zr, input logic jp);
        logic [31:0] seq;
        int          off;
        seq = pc + 32'd4;
        off = $signed(ins[15:0]);
        if (jp) return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 32'd4);
        if (br && zr) return seq + 32'(off * 4);
        return seq;
    endfunction

    // Reference model: what fetch should be doing, tracked per clock
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    bit          m_boot, m_fetch, m_have, m_err;
    int          m_wait;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc <= RPC; m_instr <= 32'd0; m_boot <= 1'b1;
            m_fetch <= 1'b0; m_have <= 1'b0; m_err <= 1'b0; m_wait <= 0;
        end else if (m_boot) begin
            m_boot <= 1'b0; m_fetch <= 1'b1;
        end else if (m_fetch) begin
            if (i_imem_ack) begin
                m_instr <= i_imem_rdata; m_fetch <= 1'b0; m_have <= 1'b1; m_wait <= 0;
            end else if (m_wait == MW - 1) begin
                m_fetch <= 1'b0; m_err <= 1'b1;
            end else begin
                m_wait <= m_wait + 1;
            end
        end else if (m_have && i_instr_ready) begin
            m_have  <= 1'b0;
            m_fetch <= 1'b1;
            m_pc    <= model_next(m_pc, m_instr, i_branch, i_zero, i_jump);
        end
    end

    bit cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en) begin
            chk1 ("cyc_req",   o_imem_req,    m_fetch);
            chk32("cyc_addr",  o_imem_addr,   m_pc);
            chk1 ("cyc_valid", o_instr_valid, m_have);
            chk32("cyc_instr", o_instr,       m_instr);
            chk32("cyc_pc",    o_pc,          m_pc);
            chk32("cyc_pc4",   o_pc_plus4,    m_pc + 32'd4);
            chk1 ("cyc_err",   o_fetch_err,   m_err);
        end
    end

    // Memory responder knobs and contents
    logic [31:0] mem [logic [31:0]];
    bit ack_en   = 1'b1;
    bit rand_lat = 1'b0;
    bit spur_en  = 1'b0;
    int fix_lat  = 1;
    int ack_lat  = 1;
    int req_age  = 0;

    task automatic tick();
        @(negedge clk);
        #1;
        i_imem_ack = 1'b0;
        if (o_imem_req) begin
            if (ack_en && req_age >= ack_lat) begin
                if (!mem.exists(o_imem_addr)) mem[o_imem_addr] = $urandom;
                i_imem_ack   = 1'b1;
                i_imem_rdata = mem[o_imem_addr];
                req_age      = 0;
                ack_lat      = rand_lat ? int'($urandom_range(0, 3)) : fix_lat;
            end else begin
                req_age++;
            end
        end else begin
            req_age = 0;
            if (spur_en && $urandom_range(0, 3) == 0) begin
                i_imem_ack   = 1'b1;
                i_imem_rdata = $urandom;
            end
        end
    endtask

    task automatic wait_valid(input string nm);
        int n;
        n = 0;
        while (!o_instr_valid && n < 50) begin
            tick();
            n++;
        end
        if (!o_instr_valid) begin
            total++; bad++;
            $display("FAIL %s: got timeout want instr_valid", nm);
        end
    endtask

    task automatic wait_req(input string nm, output logic [31:0] addr);
        int n;
        n = 0;
        while (!o_imem_req && n < 50) begin
            tick();
            n++;
        end
        if (!o_imem_req) begin
            total++; bad++;
            $display("FAIL %s: got timeout want imem_req", nm);
        end
        addr = o_imem_addr;
    endtask

    task automatic retire(input logic br, input logic zr, input logic jp);
        wait_valid("retire_wait");
        i_instr_ready = 1'b1; i_branch = br; i_zero = zr; i_jump = jp;
        tick();
        i_instr_ready = 1'b0; i_branch = 1'b0; i_zero = 1'b0; i_jump = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_imem_ack = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        req_age = 0;
    endtask

    logic [31:0] a;
    logic [31:0] seq_addr [3];
    int          n_valid, nq, n_req;

    initial begin
        #1 rst = 1'b1;

        chk32("pin_beq_taken",  model_next(32'h10, 32'h1000_FFFE, 1'b1, 1'b1, 1'b0), 32'h0000_000C);
        chk32("pin_beq_not",    model_next(32'h10, 32'h1000_FFFE, 1'b1, 1'b0, 1'b0), 32'h0000_0014);
        chk32("pin_jump_wins",  model_next(32'h4000_0020, 32'h0800_0010, 1'b1, 1'b1, 1'b1), 32'h4000_0040);
        chk32("pin_wrap",       model_next(32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0, 1'b0), 32'h0000_0000);

        mem[32'h10] = 32'h1000_FFFE;
        mem[32'h14] = 32'h0800_0010;
        mem[32'h44] = 32'h1000_FFED;

        do_reset();
        cmp_en = 1'b1;
        chk32("rst_pc",    o_pc,        RPC);
        chk32("rst_pc4",   o_pc_plus4,  RPC + 32'd4);
        chk1 ("rst_req",   o_imem_req,  1'b0);
        chk1 ("rst_valid", o_instr_valid, 1'b0);
        chk32("rst_instr", o_instr,     32'd0);
        chk1 ("rst_err",   o_fetch_err, 1'b0);

        // Sequential fetch with one-cycle memory latency
        fix_lat = 1; ack_lat = 1; i_instr_ready = 1'b1;
        n_valid = 0; nq = 0;
        for (int c = 0; c < 9; c++) begin
            tick();
            if (o_instr_valid) n_valid++;
            if (o_imem_req && i_imem_ack && nq < 3) begin
                seq_addr[nq] = o_imem_addr;
                nq++;
            end
        end
        i_instr_ready = 1'b0;
        chk32("seq_valid_cnt", 32'(n_valid), 32'd3);
        chk32("seq_addr0", seq_addr[0], 32'h0);
        chk32("seq_addr1", seq_addr[1], 32'h4);
        chk32("seq_addr2", seq_addr[2], 32'h8);
        chk32("seq_pc8", o_pc, 32'h8);

        // Branch taken and not taken at 0x10
        retire(1'b0, 1'b0, 1'b0);
        retire(1'b0, 1'b0, 1'b0);
        wait_valid("beq_wait");
        chk32("beq_pc",    o_pc,    32'h10);
        chk32("beq_instr", o_instr, 32'h1000_FFFE);
        retire(1'b1, 1'b1, 1'b0);
        wait_req("beq_req", a);
        chk32("beq_taken_addr", a, 32'h0C);
        retire(1'b0, 1'b0, 1'b0);
        retire(1'b1, 1'b0, 1'b0);
        wait_req("bne_req", a);
        chk32("beq_not_addr", a, 32'h14);

        // Jump beats a simultaneous taken branch
        wait_valid("jmp_wait");
        chk32("jmp_instr", o_instr, 32'h0800_0010);
        retire(1'b1, 1'b1, 1'b1);
        wait_req("jmp_req", a);
        chk32("jmp_addr", a, 32'h40);

        // Decode stall holds everything
        wait_valid("stall_wait");
        for (int c = 0; c < 5; c++) begin
            tick();
            chk32("stall_pc",    o_pc, 32'h40);
            chk1 ("stall_req",   o_imem_req, 1'b0);
            chk1 ("stall_valid", o_instr_valid, 1'b1);
        end
        retire(1'b0, 1'b0, 1'b0);
        chk1 ("stall_next_req", o_imem_req, 1'b1);
        chk32("stall_next_addr", o_imem_addr, 32'h44);

        // Backward branch below zero, then sequential wrap
        retire(1'b1, 1'b1, 1'b0);
        wait_req("wrap_req", a);
        chk32("wrap_branch_addr", a, 32'hFFFF_FFFC);
        chk32("wrap_pc4", o_pc_plus4, 32'h0);
        retire(1'b0, 1'b0, 1'b0);
        wait_req("wrap_seq_req", a);
        chk32("wrap_seq_addr", a, 32'h0);

        // Asynchronous reset in the middle of a request
        ack_en = 1'b0;
        tick();
        wait_req("arst_req", a);
        #2 rst = 1'b1;
        #1;
        chk1 ("arst_req_drop", o_imem_req, 1'b0);
        chk32("arst_pc", o_pc, RPC);
        @(negedge clk);
        #1;
        rst = 1'b0;
        req_age = 0;
        i_imem_ack = 1'b1;
        i_imem_rdata = 32'hDEAD_BEEF;
        tick();
        chk1("late_ack_req",   o_imem_req, 1'b1);
        chk1("late_ack_valid", o_instr_valid, 1'b0);

        // Request timeout with no acknowledge
        n_req = 1;
        for (int c = 0; c < 20 && !o_fetch_err; c++) begin
            tick();
            if (o_imem_req) n_req++;
        end
        chk32("tmo_req_cycles", 32'(n_req), 32'd4);
        chk1 ("tmo_err", o_fetch_err, 1'b1);
        chk1 ("tmo_req", o_imem_req, 1'b0);
        ack_en = 1'b1; spur_en = 1'b1;
        repeat (20) tick();
        chk1("tmo_sticky", o_fetch_err, 1'b1);
        spur_en = 1'b0;
        do_reset();
        chk1("tmo_clear", o_fetch_err, 1'b0);
        wait_req("restart_req", a);
        chk32("restart_addr", a, RPC);

        // Randomized traffic
        rand_lat = 1'b1; spur_en = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            i_instr_ready = 1'($urandom_range(0, 1));
            i_branch      = 1'($urandom_range(0, 1));
            i_zero        = 1'($urandom_range(0, 1));
            i_jump        = ($urandom_range(0, 5) == 0);
            tick();
        end

        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
